board_link_ctrl: RTL and testbench

Sequencer between the Nios board-state PIOs and the serial `comms` link on the checkers board-exchange path. It handles three jobs. It takes a 256-bit board snapshot on a four-phase request from software and waits for the peer's ready line. It then launches exactly one serializer transfer and reports completion or timeout. On the receive side it latches each board delivered by the deserializer into a stable holding register and withholds local ready until software acknowledges it.

---
 rtl/checkers_pkg.sv | 16 +
 rtl/board_link_ctrl_if.sv | 33 +++
 rtl/board_link_ctrl_sync2.sv | 21 ++
 rtl/board_link_ctrl.sv | 131 +++++++++++++
 tb/tb_board_link_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/checkers_pkg.sv
// Shared types and constants for the checkers board-exchange path.
package checkers_pkg;

   localparam int BOARD_W         = 256;
   localparam int TIMEOUT_DEFAULT = 1_000_000;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_PEER = 3'd1,
      ST_START     = 3'd2,
      ST_SENDING   = 3'd3,
      ST_DONE      = 3'd4,
      ST_ERROR     = 3'd5
   } link_state_t;

endpackage

// File: rtl/board_link_ctrl_if.sv
// Software/serializer/deserializer signal bundle for board_link_ctrl.
interface board_link_if #(
   parameter int BOARD_W = checkers_pkg::BOARD_W
) ();
   logic               send_req;
   logic [BOARD_W-1:0] send_board;
   logic               send_ack;
   logic               send_err;
   logic [BOARD_W-1:0] tx_board;
   logic               tx_start;
   logic               tx_busy;
   logic               peer_ready;
   logic               local_ready;
   logic               rx_new;
   logic [BOARD_W-1:0] rx_board_in;
   logic [BOARD_W-1:0] rx_board;
   logic               rx_valid;
   logic               rx_ack;
   logic               rx_overrun;
   logic [2:0]         state;

   // master: software + serializer side; slave: the controller
   modport master (
      output send_req, send_board, tx_busy, peer_ready, rx_new, rx_board_in, rx_ack,
      input  send_ack, send_err, tx_board, tx_start, local_ready, rx_board, rx_valid,
             rx_overrun, state
   );
   modport slave (
      input  send_req, send_board, tx_busy, peer_ready, rx_new, rx_board_in, rx_ack,
      output send_ack, send_err, tx_board, tx_start, local_ready, rx_board, rx_valid,
             rx_overrun, state
   );
endinterface

// File: rtl/board_link_ctrl_sync2.sv
// 2-FF synchronizer for a single asynchronous GPIO input.
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic s1_q, s2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d;
         s2_q <= s1_q;
      end
   end

   assign q = s2_q;
endmodule

// File: rtl/board_link_ctrl.sv
// Board-exchange sequencer: snapshot + single serializer launch on TX,
// holding register with software acknowledge on RX.
module board_link_ctrl
   import checkers_pkg::*;
#(
   parameter int BOARD_W        = checkers_pkg::BOARD_W,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
   parameter int CNT_W          = 20   // 2**CNT_W must exceed TIMEOUT_CYCLES
) (
   input  logic        clk,
   input  logic        rst,
   board_link_if.slave link
);
   link_state_t        state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_seen_q, busy_seen_d;
   logic [BOARD_W-1:0] tx_board_q, tx_board_d;
   logic               tx_start_q, tx_start_d;
   logic               send_ack_q, send_ack_d;
   logic               send_err_q, send_err_d;
   logic [BOARD_W-1:0] rx_board_q, rx_board_d;
   logic               rx_valid_q, rx_valid_d;
   logic               rx_overrun_q, rx_overrun_d;
   logic               local_ready_q, local_ready_d;
   logic               peer_rdy_s;
   logic               timeout;

   sync2 u_peer_sync (
      .clk   (clk),
      .rst_n (rst),
      .d     (link.peer_ready),
      .q     (peer_rdy_s)
   );

   assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      busy_seen_d = busy_seen_q;
      tx_board_d  = tx_board_q;
      case (state_q)
         ST_IDLE: begin
            if (link.send_req) begin
               state_d    = ST_WAIT_PEER;
               tx_board_d = link.send_board;
               cnt_d      = '0;
            end
         end
         ST_WAIT_PEER: begin
            if (peer_rdy_s)   state_d = ST_START;
            else if (timeout) state_d = ST_ERROR;
            else              cnt_d   = cnt_q + CNT_W'(1);
         end
         ST_START: begin
            state_d     = ST_SENDING;
            cnt_d       = '0;
            busy_seen_d = 1'b0;
         end
         ST_SENDING: begin
            // completion needs a seen busy period so a slow serializer is not mistaken for done
            if (busy_seen_q && !link.tx_busy) state_d = ST_DONE;
            else if (timeout)                 state_d = ST_ERROR;
            else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (link.tx_busy) busy_seen_d = 1'b1;
            end
         end
         ST_DONE, ST_ERROR: begin
            if (!link.send_req) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      tx_start_d = (state_d == ST_START);
      send_ack_d = (state_d == ST_DONE);
      send_err_d = (state_d == ST_ERROR);
   end

   always_comb begin
      rx_board_d   = rx_board_q;
      rx_valid_d   = rx_valid_q;
      rx_overrun_d = rx_overrun_q;
      if (link.rx_new) begin
         // an ack in the same cycle frees the holding register for the new board
         if (!rx_valid_q || link.rx_ack) rx_board_d   = link.rx_board_in;
         else                            rx_overrun_d = 1'b1;
         rx_valid_d = 1'b1;
      end else if (link.rx_ack) begin
         rx_valid_d = 1'b0;
      end
      local_ready_d = ~rx_valid_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         busy_seen_q   <= 1'b0;
         tx_board_q    <= '0;
         tx_start_q    <= 1'b0;
         send_ack_q    <= 1'b0;
         send_err_q    <= 1'b0;
         rx_board_q    <= '0;
         rx_valid_q    <= 1'b0;
         rx_overrun_q  <= 1'b0;
         local_ready_q <= 1'b1;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         busy_seen_q   <= busy_seen_d;
         tx_board_q    <= tx_board_d;
         tx_start_q    <= tx_start_d;
         send_ack_q    <= send_ack_d;
         send_err_q    <= send_err_d;
         rx_board_q    <= rx_board_d;
         rx_valid_q    <= rx_valid_d;
         rx_overrun_q  <= rx_overrun_d;
         local_ready_q <= local_ready_d;
      end
   end

   assign link.state       = state_q;
   assign link.tx_board    = tx_board_q;
   assign link.tx_start    = tx_start_q;
   assign link.send_ack    = send_ack_q;
   assign link.send_err    = send_err_q;
   assign link.rx_board    = rx_board_q;
   assign link.rx_valid    = rx_valid_q;
   assign link.rx_overrun  = rx_overrun_q;
   assign link.local_ready = local_ready_q;
endmodule

// File: tb/tb_board_link_ctrl.sv
// Scoreboard bench for board_link_ctrl: driver pushes expected events, negedge monitor checks them.
module tb_board_link_ctrl;
   localparam int BW = 256;
   localparam int TO = 50;

   typedef struct {
      int          cyc;
      logic [BW-1:0] board;
   } start_exp_t;

   typedef struct {
      int          cyc;
      logic [BW-1:0] board;
      logic        valid;
      logic        ovr;
      logic        lr;
   } rx_exp_t;

   logic clk;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   start_exp_t q_start[$];
   int         q_ack[$];
   int         q_err[$];
   rx_exp_t    q_rx[$];

   board_link_if #(.BOARD_W(BW)) bus ();

   board_link_ctrl #(.BOARD_W(BW), .TIMEOUT_CYCLES(TO), .CNT_W(20)) dut (
      .clk  (clk),
      .rst  (rst),
      .link (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic unexpected(input string nm);
      checks++;
      errors++;
      $display("FAIL %s unexpected event at cyc=%0d", nm, cyc);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_rx(input int c, input logic [BW-1:0] b, input logic v, input logic o,
                          input logic l);
      rx_exp_t e;
      e.cyc = c; e.board = b; e.valid = v; e.ovr = o; e.lr = l;
      q_rx.push_back(e);
   endtask

   task automatic push_start(input int c, input logic [BW-1:0] b);
      start_exp_t e;
      e.cyc = c; e.board = b;
      q_start.push_back(e);
   endtask

   task automatic rx_pulse(input logic [BW-1:0] b, input logic ack);
      bus.rx_board_in = b;
      bus.rx_new      = 1'b1;
      bus.rx_ack      = ack;
      step(1);
      bus.rx_new = 1'b0;
      bus.rx_ack = 1'b0;
      step(2);
   endtask

   // Monitor
   logic          mon_init = 1'b0;
   logic          prev_ack, prev_err;
   logic [BW+2:0] prev_rx;

   always @(negedge clk) begin
      start_exp_t se;
      rx_exp_t    re;
      int         ce;
      if (mon_init) begin
         if (bus.tx_start) begin
            if (q_start.size() == 0) unexpected("tx_start");
            else begin
               se = q_start.pop_front();
               chk("tx_start_cyc", BW'(cyc), BW'(se.cyc));
               chk("tx_board_at_start", bus.tx_board, se.board);
            end
         end
         if (bus.send_ack && !prev_ack) begin
            if (q_ack.size() == 0) unexpected("send_ack");
            else begin
               ce = q_ack.pop_front();
               chk("send_ack_cyc", BW'(cyc), BW'(ce));
            end
         end
         if (bus.send_err && !prev_err) begin
            if (q_err.size() == 0) unexpected("send_err");
            else begin
               ce = q_err.pop_front();
               chk("send_err_cyc", BW'(cyc), BW'(ce));
            end
         end
         if ({bus.rx_board, bus.rx_valid, bus.rx_overrun, bus.local_ready} !== prev_rx) begin
            if (q_rx.size() == 0) unexpected("rx_change");
            else begin
               re = q_rx.pop_front();
               chk("rx_cyc", BW'(cyc), BW'(re.cyc));
               chk("rx_board", bus.rx_board, re.board);
               chk("rx_flags", BW'({bus.rx_valid, bus.rx_overrun, bus.local_ready}),
                   BW'({re.valid, re.ovr, re.lr}));
            end
         end
      end
      prev_ack <= bus.send_ack;
      prev_err <= bus.send_err;
      prev_rx  <= {bus.rx_board, bus.rx_valid, bus.rx_overrun, bus.local_ready};
      mon_init <= 1'b1;
   end

   // Driver
   initial begin
      logic [BW-1:0] b1, b2, b3, ones, ra5, rc3, r5a, r3c;
      int c, r;
      b1   = {8{32'h0707_5050}};
      b2   = {8{32'h1234_ABCD}};
      b3   = {8{32'hDEAD_BEEF}};
      ones = '1;
      ra5  = {32{8'hA5}};
      rc3  = {32{8'hC3}};
      r5a  = {32{8'h5A}};
      r3c  = {32{8'h3C}};

      rst = 1'b0;
      bus.send_req = 0; bus.send_board = '0; bus.tx_busy = 0; bus.peer_ready = 0;
      bus.rx_new = 0; bus.rx_board_in = '0; bus.rx_ack = 0;
      step(3);
      chk("rst_state", BW'(bus.state), BW'(0));
      chk("rst_flags", BW'({bus.send_ack, bus.send_err, bus.tx_start, bus.rx_valid,
                           bus.rx_overrun, bus.local_ready}), BW'(6'b000001));
      chk("rst_tx_board", bus.tx_board, '0);
      chk("rst_rx_board", bus.rx_board, '0);
      rst = 1'b1;
      bus.peer_ready = 1'b1;
      step(4);

      // Nominal send, snapshot frozen while send_board changes
      c = cyc;
      push_start(c + 2, b1);
      q_ack.push_back(c + 34);
      bus.send_board = b1;
      bus.send_req   = 1'b1;
      step(1); chk("nom_wait_peer", BW'(bus.state), BW'(1));
      step(1); chk("nom_start", BW'(bus.state), BW'(2));
      step(1); chk("nom_sending", BW'(bus.state), BW'(3));
      bus.send_board = ones;
      bus.tx_busy    = 1'b1;
      step(10); chk("snapshot_stable", bus.tx_board, b1);
      step(20); bus.tx_busy = 1'b0;
      step(1); chk("nom_done", BW'(bus.state), BW'(4));
      step(5); chk("ack_held", BW'(bus.send_ack), BW'(1));
      bus.send_req = 1'b0;
      step(1); chk("nom_idle", BW'(bus.state), BW'(0));
      chk("ack_cleared", BW'(bus.send_ack), BW'(0));
      step(2);

      // Serializer stuck busy: SENDING timeout
      c = cyc;
      push_start(c + 2, b2);
      q_err.push_back(c + 53);
      bus.send_board = b2;
      bus.send_req   = 1'b1;
      step(3); bus.tx_busy = 1'b1;
      step(50); chk("send_to_error", BW'(bus.state), BW'(5));
      bus.send_req = 1'b0;
      bus.tx_busy  = 1'b0;
      step(1); chk("send_to_idle", BW'(bus.state), BW'(0));

      // Peer absent, send_req dropped early (ignored)
      bus.peer_ready = 1'b0;
      step(3);
      c = cyc;
      q_err.push_back(c + TO + 1);
      bus.send_req = 1'b1;
      step(1); chk("peer_wait", BW'(bus.state), BW'(1));
      bus.send_req = 1'b0;
      step(TO - 1); chk("peer_still_wait", BW'(bus.state), BW'(1));
      step(1); chk("peer_error", BW'(bus.state), BW'(5));
      step(1); chk("peer_idle", BW'(bus.state), BW'(0));
      bus.peer_ready = 1'b1;
      step(4);

      // Receive path
      push_rx(cyc + 1, ra5, 1'b1, 1'b0, 1'b0);
      rx_pulse(ra5, 1'b0);
      bus.rx_ack = 1'b1;
      push_rx(cyc + 1, ra5, 1'b0, 1'b0, 1'b1);
      step(1); bus.rx_ack = 1'b0;
      step(2);
      push_rx(cyc + 1, rc3, 1'b1, 1'b0, 1'b0);
      rx_pulse(rc3, 1'b0);
      push_rx(cyc + 1, r5a, 1'b1, 1'b0, 1'b0);
      rx_pulse(r5a, 1'b1);
      push_rx(cyc + 1, r5a, 1'b1, 1'b1, 1'b0);
      rx_pulse(r3c, 1'b0);
      chk("overrun_sticky", BW'(bus.rx_overrun), BW'(1));

      // Reset in SENDING
      c = cyc;
      push_start(c + 2, b3);
      bus.send_board = b3;
      bus.send_req   = 1'b1;
      step(3); bus.tx_busy = 1'b1;
      step(5);
      r = cyc;
      push_rx(r, '0, 1'b0, 1'b0, 1'b1);
      rst = 1'b0;
      #1;
      chk("mid_rst_state", BW'(bus.state), BW'(0));
      chk("mid_rst_tx_board", bus.tx_board, '0);
      chk("mid_rst_flags", BW'({bus.send_ack, bus.send_err, bus.tx_start, bus.rx_valid,
                               bus.rx_overrun, bus.local_ready}), BW'(6'b000001));
      step(1);
      rst = 1'b1;
      bus.send_req = 1'b0;
      bus.tx_busy  = 1'b0;
      step(10);
      chk("post_rst_idle", BW'(bus.state), BW'(0));

      chk("left_start", BW'(q_start.size()), BW'(0));
      chk("left_ack", BW'(q_ack.size()), BW'(0));
      chk("left_err", BW'(q_err.size()), BW'(0));
      chk("left_rx", BW'(q_rx.size()), BW'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
